// File: rtl/hero_motion_ctrl.sv
// hero_motion_ctrl: runner-game hero vertical motion (jump, gravity, fast-fall, duck, landing)
// Ports: clk_5ms 200 Hz game tick; reset sync active-high; enable=0 freezes all state;
//        jump/down button levels; y_hero hero top row; showmode run-animation frame select;
//        ducking/airborne registered state flags; landed one-cycle touchdown pulse.
// Option: define HERO_DOUBLE_JUMP_EN to accept one extra jump while airborne.
module hero_motion_ctrl #(
    parameter int Y_W      = 32,
    parameter int VEL_W    = 8,
    parameter int Y_GROUND = 448,
    parameter int V0       = 8,
    parameter int GRAVITY  = 1,
    parameter int GRAV_DIV = 4,
    parameter int ANIM_DIV = 20
) (
    input  logic           clk_5ms,
    input  logic           reset,
    input  logic           enable,
    input  logic           jump,
    input  logic           down,
    output logic [Y_W-1:0] y_hero,
    output logic           showmode,
    output logic           ducking,
    output logic           airborne,
    output logic           landed
);
    localparam int GW  = $clog2(GRAV_DIV + 1);
    localparam int AW  = $clog2(ANIM_DIV + 1);
    localparam int VW1 = VEL_W + 1;
    localparam int YX  = Y_W + 1 - VEL_W;
    typedef enum logic [1:0] {GROUND, DUCK, RISE, FALL} state_t;
    state_t state, state_n;
    logic [VEL_W-1:0] vel, vel_n, vel_upd;
    logic [VEL_W:0]   vel_w, dec;
    logic [Y_W:0]     y_w;
    logic [Y_W-1:0]   y_n, y_step;
    logic [GW-1:0]    grav_cnt, grav_n;
    logic [AW-1:0]    anim_cnt, anim_n;
    logic jump_q, jump_rise, grav_hit, anim_hit, touch, show_n, landed_n;
`ifdef HERO_DOUBLE_JUMP_EN
    logic jumps_used, jumps_n;
`endif
    assign jump_rise = jump & ~jump_q;
    assign grav_hit  = grav_cnt == GW'(GRAV_DIV - 1);
    assign anim_hit  = anim_cnt == AW'(ANIM_DIV - 1);
    // Velocity math one bit wider so an underflow past the most negative value can saturate.
    assign dec     = down ? VW1'(2 * GRAVITY) : grav_hit ? VW1'(GRAVITY) : '0;
    assign vel_w   = {vel[VEL_W-1], vel} - dec;
    assign vel_upd = (vel_w[VEL_W] & ~vel_w[VEL_W-1]) ? {1'b1, {(VEL_W-1){1'b0}}} : vel_w[VEL_W-1:0];
    // Position math one bit wider (signed) so rising past row 0 clamps instead of wrapping.
    assign y_w    = {1'b0, y_hero} - {{YX{vel[VEL_W-1]}}, vel};
    assign y_step = y_w[Y_W] ? '0 : y_w[Y_W-1:0];
    assign touch  = ~y_w[Y_W] & (y_w[Y_W-1:0] >= Y_W'(Y_GROUND));
    always_comb begin
        state_n  = state;
        y_n      = y_hero;
        vel_n    = vel;
        grav_n   = grav_cnt;
        landed_n = 1'b0;
`ifdef HERO_DOUBLE_JUMP_EN
        jumps_n  = jumps_used;
`endif
        if (state == GROUND || state == DUCK) begin
            if (jump_rise) begin
                state_n = RISE;
                vel_n   = VEL_W'(V0);
                grav_n  = '0;
            end else
                state_n = down ? DUCK : GROUND;
        end else begin
            y_n    = y_step;
            vel_n  = vel_upd;
            grav_n = (down || grav_hit) ? '0 : grav_cnt + 1'b1;
            if (state == RISE && (vel_upd[VEL_W-1] || vel_upd == '0))
                state_n = FALL;
            if (state == FALL && touch) begin
                y_n      = Y_W'(Y_GROUND);
                vel_n    = '0;
                grav_n   = '0;
                landed_n = 1'b1;
                state_n  = down ? DUCK : GROUND;
`ifdef HERO_DOUBLE_JUMP_EN
                jumps_n  = 1'b0;
            end else if (jump_rise && !jumps_used) begin
                vel_n    = VEL_W'(V0);
                grav_n   = '0;
                state_n  = RISE;
                jumps_n  = 1'b1;
`endif
            end
        end
        // Animation follows the next state so showmode is already 0 in the first off-ground cycle.
        show_n = (state_n == GROUND) && (anim_hit ? ~showmode : showmode);
        anim_n = (state_n != GROUND || anim_hit) ? '0 : anim_cnt + 1'b1;
    end
    always_ff @(posedge clk_5ms) begin
        if (reset) begin
            state    <= GROUND;
            y_hero   <= Y_W'(Y_GROUND);
            vel      <= '0;
            grav_cnt <= '0;
            anim_cnt <= '0;
            showmode <= 1'b0;
            ducking  <= 1'b0;
            airborne <= 1'b0;
            landed   <= 1'b0;
            jump_q   <= 1'b0;
`ifdef HERO_DOUBLE_JUMP_EN
            jumps_used <= 1'b0;
`endif
        end else if (enable) begin
            state    <= state_n;
            y_hero   <= y_n;
            vel      <= vel_n;
            grav_cnt <= grav_n;
            anim_cnt <= anim_n;
            showmode <= show_n;
            ducking  <= state_n == DUCK;
            airborne <= state_n == RISE || state_n == FALL;
            landed   <= landed_n;
            jump_q   <= jump;
`ifdef HERO_DOUBLE_JUMP_EN
            jumps_used <= jumps_n;
`endif
        end else
            landed <= 1'b0;
    end
endmodule

// File: tb/tb_hero_motion_ctrl.sv
// tb_hero_motion_ctrl: scoreboard bench for hero_motion_ctrl with a rule-level reference model
module tb_hero_motion_ctrl;
    localparam int YG = 448, V0 = 8, GRAV = 1, GRAV_DIV = 4, ANIM_DIV = 20;
    localparam int S_G = 0, S_D = 1, S_R = 2, S_F = 3;
`ifdef HERO_DOUBLE_JUMP_EN
    localparam bit DJ = 1'b1;
    localparam int APEX2 = 160;
`else
    localparam bit DJ = 1'b0;
    localparam int APEX2 = 304;
`endif
    typedef struct packed {
        logic [31:0] y;
        logic        show;
        logic        duck;
        logic        air;
        logic        land;
    } obs_t;

    logic clk_5ms = 1'b0, reset = 1'b0, enable = 1'b0, jump = 1'b0, down = 1'b0;
    logic [31:0] y_hero;
    logic showmode, ducking, airborne, landed;
    int n_chk = 0, n_fail = 0, cyc = 0;
    obs_t exp_q[$];
    int m_y, m_v, m_st, m_gc, m_ac, m_jq, m_ju;
    bit m_show, m_land;

    hero_motion_ctrl dut (
        .clk_5ms(clk_5ms), .reset(reset), .enable(enable), .jump(jump), .down(down),
        .y_hero(y_hero), .showmode(showmode), .ducking(ducking), .airborne(airborne), .landed(landed)
    );

    always #5 clk_5ms = ~clk_5ms;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, expv);
        end
    endtask

    // Reference: one game tick applied to the hero's physical quantities.
    task automatic model(input bit r, input bit en, input bit j, input bit d);
        int yn, st0;
        bit jr;
        if (r) begin
            m_y = YG; m_v = 0; m_st = S_G; m_gc = 0; m_ac = 0; m_jq = 0; m_ju = 0;
            m_show = 0; m_land = 0;
        end else if (!en)
            m_land = 0;
        else begin
            jr = j && !m_jq;
            m_jq = j;
            m_land = 0;
            st0 = m_st;
            if (st0 == S_G || st0 == S_D) begin
                if (jr) begin m_st = S_R; m_v = V0; m_gc = 0; end
                else m_st = d ? S_D : S_G;
            end else begin
                yn = m_y - m_v;
                if (yn < 0) yn = 0;
                m_y = yn;
                if (d) begin
                    m_v -= 2 * GRAV;
                    m_gc = 0;
                end else begin
                    m_gc++;
                    if (m_gc == GRAV_DIV) begin m_v -= GRAV; m_gc = 0; end
                end
                if (m_v < -128) m_v = -128;
                if (st0 == S_R && m_v <= 0) m_st = S_F;
                if (st0 == S_F && yn >= YG) begin
                    m_y = YG; m_v = 0; m_gc = 0; m_land = 1; m_ju = 0;
                    m_st = d ? S_D : S_G;
                end else if (DJ && jr && m_ju == 0) begin
                    m_v = V0; m_gc = 0; m_st = S_R; m_ju = 1;
                end
            end
            if (m_st == S_G) begin
                m_ac++;
                if (m_ac == ANIM_DIV) begin m_ac = 0; m_show = !m_show; end
            end else begin
                m_ac = 0; m_show = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit en, input bit j, input bit d);
        obs_t e;
        @(negedge clk_5ms);
        reset = r; enable = en; jump = j; down = d;
        model(r, en, j, d);
        e.y = 32'(m_y); e.show = m_show; e.duck = (m_st == S_D);
        e.air = (m_st == S_R || m_st == S_F); e.land = m_land;
        exp_q.push_back(e);
        @(posedge clk_5ms);
        #1;
    endtask

    task automatic run_until_land(input bit d, input int y0, output int n, output int ymin);
        n = 0;
        ymin = y0;
        do begin
            step(0, 1, 0, d);
            n++;
            if (int'(y_hero) < ymin) ymin = int'(y_hero);
        end while (!landed && n < 300);
        if (n >= 300) chk("land_timeout", n, 0);
    endtask

    always @(posedge clk_5ms) begin
        obs_t e, a;
        cyc++;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {y_hero, showmode, ducking, airborne, landed};
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL scoreboard cyc=%0d actual y=%0d show=%b duck=%b air=%b land=%b required y=%0d show=%b duck=%b air=%b land=%b",
                         cyc, a.y, a.show, a.duck, a.air, a.land, e.y, e.show, e.duck, e.air, e.land);
            end
        end
    end

    initial begin
        int n, ymin, ytk, yf, take;
        bit prev;
        repeat (3) step(1, 1, 0, 0);
        chk("reset_y", y_hero, YG);
        chk("reset_flags", {showmode, ducking, airborne, landed}, 0);
        repeat (19) step(0, 1, 0, 0);
        chk("show_pre", showmode, 0);
        step(0, 1, 0, 0);
        chk("show_toggle", showmode, 1);
        repeat (25) step(0, 1, 0, 0);
        // single jump
        step(0, 1, 1, 0);
        chk("takeoff_y", y_hero, YG);
        chk("takeoff_air", airborne, 1);
        chk("takeoff_show", showmode, 0);
        step(0, 1, 0, 0);
        chk("first_rise_y", y_hero, 440);
        run_until_land(0, YG, n, ymin);
        chk("land_latency", n + 1, 68);
        chk("apex", ymin, 304);
        chk("land_y", y_hero, YG);
        step(0, 1, 0, 0);
        chk("land_pulse_end", landed, 0);
        // held jump triggers once
        take = 0;
        prev = airborne;
        repeat (200) begin
            step(0, 1, 1, 0);
            if (airborne && !prev) take++;
            prev = airborne;
        end
        chk("held_jump_count", take, 1);
        chk("held_jump_ground", airborne, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        chk("repress_jump", airborne, 1);
        run_until_land(0, YG, n, ymin);
        chk("repress_land", n, 68);
        // fast-fall from apex
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        repeat (32) step(0, 1, 0, 0);
        chk("ff_apex", y_hero, 304);
        run_until_land(1, 304, n, ymin);
        chk("ff_fast", n < 20, 1);
        chk("ff_duck", ducking, 1);
        step(0, 1, 0, 0);
        chk("ff_unduck", ducking, 0);
        // freeze mid-air and resume
        step(0, 1, 1, 0);
        repeat (20) step(0, 1, 0, 0);
        yf = int'(y_hero);
        repeat (50) step(0, 0, 1'($urandom), 0);
        chk("freeze_y", y_hero, yf);
        chk("freeze_air", airborne, 1);
        run_until_land(0, yf, n, ymin);
        chk("freeze_resume", 20 + n, 68);
        // reset mid-air
        step(0, 1, 1, 0);
        repeat (10) step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("rst_air_y", y_hero, YG);
        chk("rst_air_flags", {airborne, landed}, 0);
        step(0, 1, 0, 0);
        chk("rst_air_after", landed, 0);
        // second and third presses in the air
        step(0, 1, 1, 0);
        repeat (32) step(0, 1, 0, 0);
        ytk = int'(y_hero);
        step(0, 1, 1, 0);
        repeat (10) step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        run_until_land(0, ytk, n, ymin);
        chk("dj_apex", ymin, APEX2);
        // randomized traffic
        repeat (3000)
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
        #5;
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
